// File: rtl/reg_tree_arbiter.sv
// Round-robin arbiter feeding a fixed-latency register fan-out tree, with a matched valid/ID shadow pipeline.
// Optional burst locking is compiled in with `define REG_TREE_ARB_BURST_EN.
module reg_tree_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int TREE_LATENCY = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          drain,
  output logic [DATA_WIDTH-1:0]         tree_in,
  output logic                          out_valid,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic [CNT_WIDTH-1:0]          inflight,
  output logic                          idle
);

`ifdef REG_TREE_ARB_BURST_EN
  typedef enum logic [1:0] {ARB = 2'd0, DRAIN = 2'd1, LOCK = 2'd2} state_e;
`else
  typedef enum logic [0:0] {ARB = 1'b0, DRAIN = 1'b1} state_e;
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  state_e                state_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [TREE_LATENCY-1:0] vld_q;
  logic [ID_WIDTH-1:0]   id_q [TREE_LATENCY];
  logic [CNT_WIDTH-1:0]  inflight_q;
  logic [CNT_WIDTH-1:0]  inflight_d;

  logic                  arb_found;
  logic [ID_WIDTH-1:0]   arb_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  xfer;

  // Walk from farthest to nearest so the requester closest after ptr wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = arb_idx;
    case (state_q)
      ARB:     grant_valid = arb_found && !drain;
`ifdef REG_TREE_ARB_BURST_EN
      LOCK: begin
        grant_valid = 1'b1;
        grant_idx   = ptr_q;
      end
`endif
      default: grant_valid = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_valid && (grant_idx == ID_WIDTH'(gi));
    end
  endgenerate

  assign xfer    = grant_valid && req_valid[grant_idx];
  assign tree_in = xfer ? req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

  // ptr doubles as the lock owner: it always holds the last granted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      if (xfer) ptr_q <= grant_idx;
      case (state_q)
        ARB: begin
          if (drain) state_q <= DRAIN;
`ifdef REG_TREE_ARB_BURST_EN
          else if (xfer && !req_last[grant_idx]) state_q <= LOCK;
`endif
        end
`ifdef REG_TREE_ARB_BURST_EN
        LOCK: if (xfer && req_last[grant_idx]) state_q <= drain ? DRAIN : ARB;
`endif
        DRAIN: if (!drain) state_q <= ARB;
        default: state_q <= ARB;
      endcase
    end
  end

  // Shadow of the tree: clears on reset so stale tree contents never look valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < TREE_LATENCY; i++) id_q[i] <= '0;
    end else begin
      vld_q[0] <= xfer;
      id_q[0]  <= grant_idx;
      for (int i = 1; i < TREE_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[TREE_LATENCY-1];
  assign out_id    = id_q[TREE_LATENCY-1];

  assign inflight_d = inflight_q + CNT_WIDTH'(xfer) - CNT_WIDTH'(out_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  assign inflight = inflight_q;

`ifdef REG_TREE_ARB_BURST_EN
  assign idle = (state_q != LOCK) && (inflight_q == '0);
`else
  assign idle = (inflight_q == '0);
`endif

endmodule

// File: tb/tb_reg_tree_arbiter.sv
// Randomized bench for reg_tree_arbiter against a cycle-history reference model.
// The arbitration model follows the burst build when REG_TREE_ARB_BURST_EN is defined.
module tb_reg_tree_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TL = 4;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             drain;
  logic [DW-1:0]    tree_in;
  logic             out_valid;
  logic [IW-1:0]    out_id;
  logic [CW-1:0]    inflight;
  logic             idle;

  reg_tree_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .TREE_LATENCY(TL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .drain(drain), .tree_in(tree_in),
    .out_valid(out_valid), .out_id(out_id), .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: transfer history per edge plus abstract arbiter state.
  int n_edge;
  bit hv  [4096];
  int hid [4096];
  int m_last;
  bit m_locked;
  bit m_drain;
  bit m_xfer;
  int m_gnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, n_edge);
    end
  endtask

  function automatic logic [NR*DW-1:0] rand_data();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    n_edge = 0;
    for (int i = 0; i < 4096; i++) begin
      hv[i]  = 1'b0;
      hid[i] = 0;
    end
    m_last   = NR - 1;
    m_locked = 1'b0;
    m_drain  = 1'b0;
  endtask

  // A beat accepted at edge e sits in the tree after edges e..e+TL-1 and shows at the leaves after e+TL-1.
  task automatic check_regs();
    int lo;
    int cnt;
    bit exp_ov;
    lo     = n_edge - TL + 1;
    exp_ov = (lo >= 1) ? hv[lo] : 1'b0;
    cnt    = 0;
    for (int e = (lo < 1 ? 1 : lo); e <= n_edge; e++) cnt += int'(hv[e]);
    check_val("out_valid", 32'(out_valid), 32'(exp_ov));
    check_val("inflight", 32'(inflight), 32'(cnt));
    check_val("idle", 32'(idle), 32'(!m_locked && cnt == 0));
    if (exp_ov) check_val("out_id", 32'(out_id), 32'(hid[lo]));
  endtask

  task automatic run_cycle(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic d,
                           input logic [NR*DW-1:0] dat);
    logic [NR-1:0] exp_rdy;
    logic [DW-1:0] exp_tree;
    int g;
    bit x;
    @(posedge clk);
    n_edge++;
    #1;
    req_valid = v;
    req_last  = l;
    drain     = d;
    req_data  = dat;
    @(negedge clk);
    check_regs();
    exp_rdy = '0;
    g = -1;
    x = 1'b0;
    if (m_drain) begin
      m_drain = d;
    end else if (m_locked) begin
      g = m_last;
      exp_rdy[g] = 1'b1;
      x = v[g];
      if (x && l[g]) begin
        m_locked = 1'b0;
        m_drain  = d;
      end
    end else if (d) begin
      m_drain = 1'b1;
    end else begin
      for (int k = 1; k <= NR; k++) begin
        if (v[(m_last + k) % NR]) begin
          g = (m_last + k) % NR;
          break;
        end
      end
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        x = 1'b1;
        m_last = g;
`ifdef REG_TREE_ARB_BURST_EN
        if (!l[g]) m_locked = 1'b1;
`endif
      end
    end
    exp_tree = x ? dat[g*DW +: DW] : '0;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_val("tree_in", 32'(tree_in), 32'(exp_tree));
    hv[n_edge+1]  = x;
    hid[n_edge+1] = g;
    m_xfer = x;
    m_gnt  = g;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle('0, '1, 1'b0, rand_data());
  endtask

  initial begin
    int peak;
    int ov_cnt;
    int b1;
    logic [NR*DW-1:0] dat;
    logic [NR-1:0] lv;
    logic d;

    rst_n = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    drain     = 1'b0;
    model_reset();
    #12;
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_tree_in", 32'(tree_in), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_id", 32'(out_id), 32'd0);
    check_val("rst_inflight", 32'(inflight), 32'd0);
    check_val("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // All requesters valid: rotating grants.
    for (int i = 0; i < 8; i++) run_cycle('1, '1, 1'b0, rand_data());
    idle_cycles(6);

    // Single requester streaming five beats back-to-back.
    peak = 0;
    ov_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      dat = rand_data();
      dat[2*DW +: DW] = DW'(16 + i);
      if (i < 5) run_cycle(4'b0100, '1, 1'b0, dat);
      else       run_cycle('0, '1, 1'b0, dat);
      if (int'(inflight) > peak) peak = int'(inflight);
      if (out_valid) ov_cnt++;
    end
    check_val("stream_peak_inflight", 32'(peak), 32'd4);
    check_val("stream_ov_cycles", 32'(ov_cnt), 32'd5);
    check_val("stream_idle", 32'(idle), 32'd1);

    // Requester 1 burst of three beats while requester 0 competes.
    b1 = 0;
    for (int i = 0; i < 8; i++) begin
      lv = '1;
      lv[1] = (b1 == 2);
      run_cycle({2'b00, (b1 < 3), 1'b1}, lv, 1'b0, rand_data());
      if (m_xfer && m_gnt == 1) b1++;
    end
    idle_cycles(6);

    // Drain mid-stream.
    for (int i = 0; i < 3; i++) run_cycle('1, '1, 1'b0, rand_data());
    for (int i = 0; i < 5; i++) begin
      run_cycle('1, '1, 1'b1, rand_data());
      check_val("drain_ready", 32'(req_ready), 32'd0);
    end
    check_val("drain_idle", 32'(idle), 32'd1);
    for (int i = 0; i < 4; i++) run_cycle('1, '1, 1'b0, rand_data());
    idle_cycles(6);

    // Reset pulse with three beats inside the tree.
    for (int i = 0; i < 3; i++) run_cycle(4'b0001, '1, 1'b0, rand_data());
    idle_cycles(1);
    check_val("pre_rst_inflight", 32'(inflight), 32'd3);
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_pulse_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_pulse_inflight", 32'(inflight), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle('0, '1, 1'b0, rand_data());
      check_val("post_rst_out_valid", 32'(out_valid), 32'd0);
      check_val("post_rst_inflight", 32'(inflight), 32'd0);
    end

    // Wrap-around from ptr = 3 back to requester 0.
    run_cycle(4'b1000, '1, 1'b0, rand_data());
    run_cycle(4'b1001, '1, 1'b0, rand_data());
    check_val("wrap_ready", 32'(req_ready), 32'd1);
    idle_cycles(6);

    // Randomized traffic with occasional drain toggles and burst ends.
    d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) d = ~d;
      run_cycle(NR'($urandom), NR'($urandom), d, rand_data());
    end
    for (int i = 0; i < 10; i++) run_cycle('0, '1, 1'b0, rand_data());
    check_val("final_idle", 32'(idle), 32'(!m_locked));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
